ram32x8_fifo_controller: RTL and testbench
==========================================

Name: ram32x8_fifo_controller

Overview:
- Sequences the structural 32-word x 8-bit single-port RAM as a FIFO.
- Drives the RAM row selects, write enable and write data, and registers the read data.
- Arbitrates one access per cycle between a push requester and a pop requester.
- Keeps the read/write pointers, occupancy count and full/empty flags.

Parameters:
DATA_WIDTH, 8, word width (matches the 8-bit memory-cell row)
ADDR_WIDTH, 5, address bits
DEPTH, 32, words; must equal 2**ADDR_WIDTH

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Push_Req  input  1  write request; held until Push_Ack
Data_In  input  DATA_WIDTH  write data; stable while Push_Req is high
Push_Ack  output  1  push granted this cycle (combinational)
Pop_Req  input  1  read request; held until Pop_Ack
Pop_Ack  output  1  pop granted this cycle (combinational)
Data_Out  output  DATA_WIDTH  registered read data
Data_Valid  output  1  Data_Out updated by the previous cycle's pop (one-cycle pulse)
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Count  output  ADDR_WIDTH+1  occupancy 0..DEPTH
RAM_Row_Select  output  DEPTH  one-hot word select; all zero when idle
RAM_Write_Enable  output  1  write strobe to all cells
RAM_Data_In  output  DATA_WIDTH  data to the RAM cell inputs
RAM_Data_Out  input  DATA_WIDTH  data from the selected RAM row (combinational)

Behaviour:
- Reset (synchronous, also mid-operation) clears:
  - Write_Pointer = 0, Read_Pointer = 0, Count = 0
  - Data_Out = 0, Data_Valid = 0
  - Last_Grant = POP, so push wins the first tie
  - Empty = 1, Full = 0, no acks, RAM_Row_Select = 0, RAM_Write_Enable = 0
- Eligibility:
  - push_ok = Push_Req & ~Full
  - pop_ok = Pop_Req & ~Empty
- Arbiter, combinational, one grant per cycle:
  - Only one side eligible: grant it.
  - Both eligible: grant the side opposite Last_Grant (round-robin).
  - Neither eligible: idle.
  - A request on Full or Empty is not acked and is never dropped; the requester keeps holding it.
- Push grant, cycle t:
  - Push_Ack = 1, RAM_Row_Select = onehot(Write_Pointer), RAM_Write_Enable = 1.
  - RAM_Data_In = Data_In.
  - At the edge ending t: Write_Pointer += 1 (mod DEPTH), Count += 1, Last_Grant = PUSH.
- Pop grant, cycle t:
  - Pop_Ack = 1, RAM_Row_Select = onehot(Read_Pointer), RAM_Write_Enable = 0.
  - At the edge ending t: Data_Out = RAM_Data_Out, Read_Pointer += 1 (mod DEPTH), Count -= 1, Last_Grant = POP.
  - Data_Valid = 1 during cycle t+1 only.
- Idle cycle: RAM_Row_Select = 0, RAM_Write_Enable = 0, Data_Valid cleared next edge, Data_Out holds.
- RAM_Data_In is driven with Data_In every cycle; it is ignored unless RAM_Write_Enable = 1.
- Pointers wrap 31 -> 0 naturally on ADDR_WIDTH bits.
- Count never exceeds DEPTH and never goes below 0; Full and Empty decode from Count.
- Push then pop of the same address in consecutive cycles returns the newly written word; there is no bypass path.
- Pop latency: 1 cycle from Pop_Ack to Data_Valid. Throughput: 1 access per cycle total.

Decomposition:
- Shared package:
  - DATA_WIDTH, ADDR_WIDTH, DEPTH constants
  - grant encoding, PUSH = 0 and POP = 1
- One natural sub-module, row_decoder_5to32:
  - ADDR_WIDTH-to-DEPTH one-hot decoder with enable.
  - Enable low gives all zeros.
  - Shared with the RAM's own structural address decode.

Test Plan:
- Reset, then idle 3 cycles -> Empty=1, Full=0, Count=0, RAM_Row_Select=0, Data_Valid=0.
- Push 0xA5 and 0x3C, then pop twice:
  - RAM_Row_Select = 0x1 then 0x2 with RAM_Write_Enable = 1.
  - Data_Out = 0xA5 then 0x3C, each with Data_Valid one cycle after its Pop_Ack; Count returns to 0.
- Fill 32 pushes (data = index), then a 33rd Push_Req -> Full=1, Count=32, Push_Ack=0; Write_Pointer wraps to 0.
- Drain 32 pops -> data 0..31 in order; Pop_Req on Empty gets Pop_Ack=0.
- Count=4 with Push_Req and Pop_Req held high 4 cycles:
  - Grants alternate PUSH, POP, PUSH, POP.
  - Count returns to 4; order is preserved.
- Assert Reset in the same cycle as a granted push at Count=10 -> next cycle Count=0, pointers 0, Data_Valid=0; the subsequent pop is refused.

Source files
------------

// File: rtl/ram32x8_fifo_controller_pkg.sv
// Shared constants, grant encoding and pointer/count helpers for the
// 32x8 single-port RAM FIFO controller.
package ram32x8_fifo_controller_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 32;

    typedef enum logic {
        GRANT_PUSH = 1'b0,
        GRANT_POP  = 1'b1
    } grant_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] ptr);
        return ptr + PTR_ONE;
    endfunction

endpackage

// File: rtl/ram32x8_fifo_controller_if.sv
// Requester-side bus of the FIFO controller: push/pop handshakes, read data
// and occupancy status.
interface ram32x8_fifo_controller_if;
    import ram32x8_fifo_controller_pkg::*;

    logic                  push_req;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  push_ack;
    logic                  pop_req;
    logic                  pop_ack;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output push_req, data_in, pop_req,
        input  push_ack, pop_ack, data_out, data_valid, full, empty, count
    );

    modport slave (
        input  push_req, data_in, pop_req,
        output push_ack, pop_ack, data_out, data_valid, full, empty, count
    );

endinterface

// File: rtl/ram32x8_fifo_controller_row_decoder_5to32.sv
// Address-to-one-hot row decoder with enable; the same decode the RAM array
// uses for its own word lines.
module row_decoder_5to32
    import ram32x8_fifo_controller_pkg::*;
(
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DEPTH-1:0]      o_row
);

    // One-hot decode, forced to all zeros when disabled
    always_comb begin
        o_row = {DEPTH{1'b0}};
        if (i_en) begin
            o_row[i_addr] = 1'b1;
        end else begin
            o_row = {DEPTH{1'b0}};
        end
    end

endmodule

// File: rtl/ram32x8_fifo_controller.sv
// FIFO sequencer for the 32x8 single-port RAM: round-robin push/pop arbiter,
// pointers, occupancy and registered read data.
module ram32x8_fifo_controller
    import ram32x8_fifo_controller_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    ram32x8_fifo_controller_if.slave    fifo,
    output logic [DEPTH-1:0]            o_ram_row_select,
    output logic                        o_ram_write_enable,
    output logic [DATA_WIDTH-1:0]       o_ram_data_in,
    input  logic [DATA_WIDTH-1:0]       i_ram_data_out
);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    grant_t                r_last_grant;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_grant_push;
    logic                  w_grant_pop;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_full    = (r_count == COUNT_FULL);
    assign w_empty   = (r_count == {(ADDR_WIDTH+1){1'b0}});
    assign w_push_ok = fifo.push_req & ~w_full;
    assign w_pop_ok  = fifo.pop_req & ~w_empty;

    // Single-grant arbiter; on a tie the side not served last wins
    always_comb begin
        w_grant_push = 1'b0;
        w_grant_pop  = 1'b0;
        if (w_push_ok && w_pop_ok) begin
            w_grant_push = (r_last_grant == GRANT_POP);
            w_grant_pop  = (r_last_grant == GRANT_PUSH);
        end else begin
            w_grant_push = w_push_ok;
            w_grant_pop  = w_pop_ok;
        end
    end

    assign w_addr = w_grant_push ? r_wr_ptr : r_rd_ptr;

    row_decoder_5to32 u_row_decoder (
        .i_en   (w_grant_push | w_grant_pop),
        .i_addr (w_addr),
        .o_row  (o_ram_row_select)
    );

    assign o_ram_write_enable = w_grant_push;
    assign o_ram_data_in      = fifo.data_in;

    assign fifo.push_ack   = w_grant_push;
    assign fifo.pop_ack    = w_grant_pop;
    assign fifo.data_out   = r_data_out;
    assign fifo.data_valid = r_data_valid;
    assign fifo.full       = w_full;
    assign fifo.empty      = w_empty;
    assign fifo.count      = r_count;

    // Pointer, occupancy and read-data state; reset also clears mid-operation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr     <= {ADDR_WIDTH{1'b0}};
            r_count      <= {(ADDR_WIDTH+1){1'b0}};
            r_data_out   <= {DATA_WIDTH{1'b0}};
            r_data_valid <= 1'b0;
            r_last_grant <= GRANT_POP;
        end else begin
            r_data_valid <= w_grant_pop;
            if (w_grant_push) begin
                r_wr_ptr     <= ptr_next(r_wr_ptr);
                r_count      <= r_count + COUNT_ONE;
                r_last_grant <= GRANT_PUSH;
            end else if (w_grant_pop) begin
                r_data_out   <= i_ram_data_out;
                r_rd_ptr     <= ptr_next(r_rd_ptr);
                r_count      <= r_count - COUNT_ONE;
                r_last_grant <= GRANT_POP;
            end
        end
    end

endmodule

// File: tb/tb_ram32x8_fifo_controller.sv
// Directed bench for ram32x8_fifo_controller with a behavioural 32x8 RAM
// attached to the row-select/write-enable bus.
module tb_ram32x8_fifo_controller;
    import ram32x8_fifo_controller_pkg::*;

    typedef struct {
        logic        rst;
        logic        push;
        logic [7:0]  din;
        logic        pop;
        logic        e_pack;
        logic        e_popack;
        logic [31:0] e_row;
        logic        e_we;
        logic [5:0]  e_count;
        logic        e_dv;
        logic [7:0]  e_dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_row_select;
    logic        ram_write_enable;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
    logic [7:0]  mem [32];

    int n_cmp  = 0;
    int n_fail = 0;

    ram32x8_fifo_controller_if bus ();

    ram32x8_fifo_controller dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .fifo               (bus),
        .o_ram_row_select   (ram_row_select),
        .o_ram_write_enable (ram_write_enable),
        .o_ram_data_in      (ram_data_in),
        .i_ram_data_out     (ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: one-hot row write, combinational row read
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (ram_row_select[i] && ram_write_enable) mem[i] <= ram_data_in;
        end
    end

    always_comb begin
        ram_data_out = 8'h00;
        for (int j = 0; j < 32; j++) begin
            if (ram_row_select[j]) ram_data_out = mem[j];
        end
    end

    function automatic vec_t mk(input logic r, input logic pu, input logic [7:0] d, input logic po,
                                input logic pa, input logic pk, input logic [31:0] row,
                                input logic we, input logic [5:0] cnt, input logic dv,
                                input logic [7:0] dout);
        vec_t v;
        v.rst = r; v.push = pu; v.din = d; v.pop = po;
        v.e_pack = pa; v.e_popack = pk; v.e_row = row; v.e_we = we;
        v.e_count = cnt; v.e_dv = dv; v.e_dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check every output mid-cycle, then advance past the edge
    task automatic run(input vec_t v, input string tag);
        rst          = v.rst;
        bus.push_req = v.push;
        bus.data_in  = v.din;
        bus.pop_req  = v.pop;
        @(negedge clk);
        chk({tag, ".push_ack"},   32'(bus.push_ack),       32'(v.e_pack));
        chk({tag, ".pop_ack"},    32'(bus.pop_ack),        32'(v.e_popack));
        chk({tag, ".row_sel"},    ram_row_select,          v.e_row);
        chk({tag, ".we"},         32'(ram_write_enable),   32'(v.e_we));
        chk({tag, ".ram_din"},    32'(ram_data_in),        32'(v.din));
        chk({tag, ".count"},      32'(bus.count),          32'(v.e_count));
        chk({tag, ".full"},       32'(bus.full),           32'(v.e_count == 6'd32));
        chk({tag, ".empty"},      32'(bus.empty),          32'(v.e_count == 6'd0));
        chk({tag, ".data_valid"}, 32'(bus.data_valid),     32'(v.e_dv));
        chk({tag, ".data_out"},   32'(bus.data_out),       32'(v.e_dout));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [28];

    initial begin
        //          rst   push  din    pop   pack  pkack row           we    cnt    dv    dout
        tbl[0]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h00);
        tbl[1]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h00);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h00);
        tbl[3]  = mk(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 6'd0, 1'b0, 8'h00);
        tbl[4]  = mk(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 6'd1, 1'b0, 8'h00);
        tbl[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 6'd2, 1'b0, 8'h00);
        tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 6'd1, 1'b1, 8'hA5);
        tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b1, 8'h3C);
        tbl[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h3C);
        tbl[9]  = mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b1, 6'd0, 1'b0, 8'h3C);
        tbl[10] = mk(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 6'd1, 1'b0, 8'h3C);
        tbl[11] = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 6'd2, 1'b0, 8'h3C);
        tbl[12] = mk(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 1'b1, 6'd3, 1'b0, 8'h3C);
        tbl[13] = mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 6'd4, 1'b0, 8'h3C);
        tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 6'd5, 1'b0, 8'h3C);
        // Count 4, both sides requesting: push, pop, push, pop
        tbl[15] = mk(1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 1'b1, 6'd4, 1'b1, 8'h11);
        tbl[16] = mk(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 6'd5, 1'b0, 8'h11);
        tbl[17] = mk(1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 6'd4, 1'b1, 8'h22);
        tbl[18] = mk(1'b0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 6'd5, 1'b0, 8'h22);
        tbl[19] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd4, 1'b1, 8'h33);
        tbl[20] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 6'd4, 1'b0, 8'h33);
        tbl[21] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 6'd3, 1'b1, 8'h44);
        tbl[22] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 6'd2, 1'b1, 8'h55);
        tbl[23] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 6'd1, 1'b1, 8'h66);
        tbl[24] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b1, 8'h77);
        tbl[25] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h77);
        tbl[26] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h77);
        tbl[27] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h00);

        rst = 1'b1;
        bus.push_req = 1'b0;
        bus.data_in  = 8'h00;
        bus.pop_req  = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 28; k++) run(tbl[k], $sformatf("tbl%0d", k));

        // Fill from address 0; the 33rd request is held off while full
        for (int k = 0; k < 32; k++) begin
            run(mk(1'b0, 1'b1, 8'(k), 1'b0, 1'b1, 1'b0, 32'h0000_0001 << k, 1'b1,
                   6'(k), 1'b0, 8'h00), $sformatf("fill%0d", k));
        end
        run(mk(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd32, 1'b0, 8'h00), "push_full");

        // Drain in order, then a refused pop on empty
        for (int k = 0; k < 32; k++) begin
            run(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0001 << k, 1'b0,
                   6'(32 - k), (k > 0), (k > 0) ? 8'(k - 1) : 8'h00), $sformatf("drain%0d", k));
        end
        run(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b1, 8'd31), "pop_empty");

        // Write pointer wrapped back to row 0; build up to count 10
        for (int k = 0; k < 10; k++) begin
            run(mk(1'b0, 1'b1, 8'h5A + 8'(k), 1'b0, 1'b1, 1'b0, 32'h0000_0001 << k, 1'b1,
                   6'(k), 1'b0, 8'd31), $sformatf("refill%0d", k));
        end

        // Reset lands on the same cycle as a granted push at count 10
        run(mk(1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 1'b1, 6'd10, 1'b0, 8'd31), "rst_push");
        run(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0, 8'h00), "post_rst_pop");
        run(mk(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 6'd0, 1'b0, 8'h00), "post_rst_push");
        run(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 6'd1, 1'b0, 8'h00), "post_rst_rd");
        run(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b1, 8'hC3), "post_rst_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
